// File: rtl/serial_negator.sv
// ---------------------------------------------------------------------------
// serial_negator
//
// Bit-serial word complementer for the arithmetic datapath. A WIDTH-bit word
// arrives one bit per accepted cycle, LSB first, and leaves one cycle later,
// also LSB first, as either its two's complement (negate) or its one's
// complement (invert). When the last bit of a word goes out, the whole result
// is also presented in parallel together with an overflow flag.
//
// Negation uses the classic serial rule: copy bits up to and including the
// first 1, then invert every bit after it. A two-state FSM remembers whether
// that first 1 has been seen yet.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    in_bit is presented this cycle (always consumed)
//   in_bit      serial input data, LSB first
//   mode        0 = negate, 1 = invert; only looked at on the first bit
//   clear       synchronous abort of the word in progress
//   out_valid   out_bit is valid
//   out_bit     serial result, LSB first
//   word_valid  one-cycle pulse, word_out/ovf just updated
//   word_out    parallel result, holds until the next word_valid
//   ovf         negate of the most negative value, holds with word_out
//
// WIDTH is intended for the range 2..32.
// ---------------------------------------------------------------------------
module serial_negator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             mode,
   input  logic             clear,
   output logic             out_valid,
   output logic             out_bit,
   output logic             word_valid,
   output logic [WIDTH-1:0] word_out,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      COPY = 1'b0,
      INV  = 1'b1
   } state_e;

   state_e           state_q,      state_d;
   logic [CNT_W-1:0] bitCnt_q,     bitCnt_d;
   logic             mode_q,       mode_d;
   logic [WIDTH-1:0] shiftReg_q,   shiftReg_d;
   logic             outValid_q,   outValid_d;
   logic             outBit_q,     outBit_d;
   logic             wordValid_q,  wordValid_d;
   logic [WIDTH-1:0] wordOut_q,    wordOut_d;
   logic             ovf_q,        ovf_d;

   logic accept;
   logic firstBit;
   logic lastBit;
   logic invertMode;
   logic resultBit;
   logic ovfBit;

   // A bit is only consumed when clear is low; clear always wins, even on
   // the last bit of a word. The effective mode comes straight from the
   // input on the first bit so that bit is processed with the mode being
   // latched, and from the latched copy for the rest of the word.
   always_comb begin
      accept     = in_valid & ~clear;
      firstBit   = (bitCnt_q == '0);
      lastBit    = (bitCnt_q == LAST_CNT);
      invertMode = firstBit ? mode : mode_q;
   end

   // State register for the copy/invert FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COPY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. In negate mode the first 1 bit moves us into INV for
   // the remainder of the word. Invert mode never leaves COPY. Every word
   // starts fresh in COPY, whether it finished normally or was aborted.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = COPY;
      end else if (accept) begin
         if (lastBit) begin
            state_d = COPY;
         end else if (!invertMode && (state_q == COPY) && in_bit) begin
            state_d = INV;
         end
      end
   end

   // Output logic for the FSM: the result bit for the bit being accepted
   // and the overflow condition. Overflow can only happen when the last bit
   // is the first 1 of the word, i.e. the input was the most negative value
   // and its negation is itself.
   always_comb begin
      resultBit = in_bit;
      if (invertMode || (state_q == INV)) begin
         resultBit = ~in_bit;
      end
      ovfBit = ~invertMode & (state_q == COPY) & in_bit;
   end

   // Datapath next-state: bit counter, latched mode and the result shift
   // register. Gaps (in_valid low) leave all of these untouched. Result bits
   // enter at the MSB end so that after WIDTH shifts bit 0 of the result
   // sits at bit 0 of the register.
   always_comb begin
      bitCnt_d   = bitCnt_q;
      mode_d     = mode_q;
      shiftReg_d = shiftReg_q;
      if (clear) begin
         bitCnt_d   = '0;
         shiftReg_d = '0;
      end else if (accept) begin
         bitCnt_d   = lastBit ? '0 : bitCnt_q + CNT_W'(1);
         shiftReg_d = {resultBit, shiftReg_q[WIDTH-1:1]};
         if (firstBit) begin
            mode_d = mode;
         end
      end
   end

   // Registered outputs. The serial output follows each accepted bit by one
   // cycle. On the last bit the parallel word is taken from the shift
   // register's next value, so word_valid lines up with the final out_bit.
   // word_out and ovf keep the last completed result across aborts.
   always_comb begin
      outValid_d  = accept;
      outBit_d    = outBit_q;
      wordValid_d = accept & lastBit;
      wordOut_d   = wordOut_q;
      ovf_d       = ovf_q;
      if (accept) begin
         outBit_d = resultBit;
         if (lastBit) begin
            wordOut_d = shiftReg_d;
            ovf_d     = ovfBit;
         end
      end
   end

   // All datapath and output registers share the asynchronous reset, so a
   // reset in the middle of a word drops it immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitCnt_q    <= '0;
         mode_q      <= 1'b0;
         shiftReg_q  <= '0;
         outValid_q  <= 1'b0;
         outBit_q    <= 1'b0;
         wordValid_q <= 1'b0;
         wordOut_q   <= '0;
         ovf_q       <= 1'b0;
      end else begin
         bitCnt_q    <= bitCnt_d;
         mode_q      <= mode_d;
         shiftReg_q  <= shiftReg_d;
         outValid_q  <= outValid_d;
         outBit_q    <= outBit_d;
         wordValid_q <= wordValid_d;
         wordOut_q   <= wordOut_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid  = outValid_q;
   assign out_bit    = outBit_q;
   assign word_valid = wordValid_q;
   assign word_out   = wordOut_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_negator.sv
// ---------------------------------------------------------------------------
// tb_serial_negator
//
// Directed bench for serial_negator with WIDTH=8. Each accepted bit pushes
// its expected serial result onto a queue, and each completed word pushes
// its expected parallel result and overflow flag. Every cycle, one time unit
// after the rising edge, the DUT outputs are compared against the queues.
// Expected results come from plain arithmetic (-v or ~v), not from a copy
// of the serial algorithm.
// ---------------------------------------------------------------------------
module tb_serial_negator;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_bit;
   logic             mode;
   logic             clear;
   logic             out_valid;
   logic             out_bit;
   logic             word_valid;
   logic [WIDTH-1:0] word_out;
   logic             ovf;

   int testsRun    = 0;
   int testsFailed = 0;

   logic             expBitQ[$];
   logic [WIDTH:0]   expWordQ[$];
   logic [WIDTH-1:0] lastWord = '0;
   logic             lastOvf  = 1'b0;
   logic [WIDTH-1:0] curRes   = '0;
   logic             curOvf   = 1'b0;
   int               tbCnt    = 0;

   serial_negator #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_bit     (in_bit),
      .mode       (mode),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_bit    (out_bit),
      .word_valid (word_valid),
      .word_out   (word_out),
      .ovf        (ovf)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // One comparison: counted, and reported on mismatch.
   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected parallel result computed arithmetically.
   task automatic startWord(input logic [WIDTH-1:0] v, input logic invMode);
      logic [WIDTH-1:0] mostNeg;
      mostNeg = '0;
      mostNeg[WIDTH-1] = 1'b1;
      curRes = invMode ? ~v : (~v + WIDTH'(1));
      curOvf = !invMode && (v == mostNeg);
   endtask

   // Compare all outputs against the scoreboard for this cycle.
   task automatic checkOutput();
      logic           expBit;
      logic [WIDTH:0] expW;
      compare("out_valid", 32'(out_valid), 32'(expBitQ.size() > 0));
      if (expBitQ.size() > 0) begin
         expBit = expBitQ.pop_front();
         compare("out_bit", 32'(out_bit), 32'(expBit));
      end
      compare("word_valid", 32'(word_valid), 32'(expWordQ.size() > 0));
      if (expWordQ.size() > 0) begin
         expW     = expWordQ.pop_front();
         lastWord = expW[WIDTH-1:0];
         lastOvf  = expW[WIDTH];
      end
      compare("word_out", 32'(word_out), 32'(lastWord));
      compare("ovf", 32'(ovf), 32'(lastOvf));
   endtask

   // Drive one cycle of inputs, record expectations, then check after the edge.
   task automatic applyStimulus(input logic valid, input logic b, input logic m, input logic clr);
      in_valid = valid;
      in_bit   = b;
      mode     = m;
      clear    = clr;
      if (valid && !clr) begin
         expBitQ.push_back(curRes[tbCnt]);
         if (tbCnt == WIDTH - 1) begin
            expWordQ.push_back({curOvf, curRes});
            tbCnt = 0;
         end else begin
            tbCnt++;
         end
      end else if (clr) begin
         tbCnt = 0;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Full word; mode is driven opposite to the word's mode after bit 0 so
   // the latched copy is exercised. Optional random gaps after each bit.
   task automatic sendWord(input logic [WIDTH-1:0] v, input logic invMode, input int maxGap);
      startWord(v, invMode);
      for (int i = 0; i < WIDTH; i++) begin
         applyStimulus(1'b1, v[i], (i == 0) ? invMode : ~invMode, 1'b0);
         if (maxGap > 0) begin
            idle(int'($urandom_range(0, 32'(maxGap))));
         end
      end
   endtask

   initial begin
      logic [WIDTH-1:0] v;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      mode     = 1'b0;
      clear    = 1'b0;

      // Reset values
      #12;
      compare("rst_out_valid", 32'(out_valid), 32'd0);
      compare("rst_out_bit", 32'(out_bit), 32'd0);
      compare("rst_word_valid", 32'(word_valid), 32'd0);
      compare("rst_word_out", 32'(word_out), 32'd0);
      compare("rst_ovf", 32'(ovf), 32'd0);
      #1 rst_n = 1'b1;
      idle(2);

      // Negate 0x01 with in_valid held high
      sendWord(8'h01, 1'b0, 0);
      // Negate 0x00 then 0x80 back-to-back
      sendWord(8'h00, 1'b0, 0);
      sendWord(8'h80, 1'b0, 0);
      // Invert 0x5A with mode toggled mid-word, then invert the most negative
      sendWord(8'h5A, 1'b1, 0);
      sendWord(8'h80, 1'b1, 0);
      idle(1);
      // Negate 0x06 with random gaps
      sendWord(8'h06, 1'b0, 3);
      idle(2);

      // Abort 0x33 after 5 bits (clear together with a valid bit), then 0x02
      v = 8'h33;
      startWord(v, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, v[i], 1'b0, 1'b0);
      applyStimulus(1'b1, v[5], 1'b0, 1'b1);
      sendWord(8'h02, 1'b0, 0);

      // Clear coinciding with the last bit
      v = 8'hC4;
      startWord(v, 1'b0);
      for (int i = 0; i < WIDTH - 1; i++) applyStimulus(1'b1, v[i], 1'b0, 1'b0);
      applyStimulus(1'b1, v[WIDTH-1], 1'b0, 1'b1);
      idle(2);
      sendWord(8'h01, 1'b0, 0);

      // Asynchronous reset after 3 bits
      v = 8'hE5;
      startWord(v, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, v[i], 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      compare("arst_out_valid", 32'(out_valid), 32'd0);
      compare("arst_out_bit", 32'(out_bit), 32'd0);
      compare("arst_word_valid", 32'(word_valid), 32'd0);
      compare("arst_word_out", 32'(word_out), 32'd0);
      compare("arst_ovf", 32'(ovf), 32'd0);
      expBitQ.delete();
      expWordQ.delete();
      tbCnt    = 0;
      lastWord = '0;
      lastOvf  = 1'b0;
      #1 rst_n = 1'b1;
      idle(1);
      sendWord(8'h7F, 1'b0, 0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
